// File: rtl/mem_pkg.sv
// Shared types for the main-memory arbiter and its write path.
//   owner_t   : who a read beat belongs to (none, icache, dcache)
//   state_t   : read-grant FSM states
//   rd_tag_t  : one stage of the returning-read owner tag pipeline
//   line_ofs(): word-offset bits inside a cache line
package mem_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IC   = 2'd1,
        OWN_DC   = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWN_IC = 2'd1,
        ST_OWN_DC = 2'd2
    } state_t;

    typedef struct packed {
        logic   vld;
        owner_t owner;
    } rd_tag_t;

    function automatic int line_ofs(input int line_width);
        return $clog2(line_width);
    endfunction

endpackage

// File: rtl/mem_wr_buffer.sv
// One-entry write buffer holding a single {addr, data} pair.
//   clk, rst   : clock, synchronous active-high reset (clears full only)
//   push       : load push_addr/push_data (caller guarantees room or same-cycle pop)
//   pop        : entry has been accepted downstream
//   full       : an entry is held
//   addr, data : held entry
module mem_wr_buffer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] data
);

    // A push wins over a pop so a same-cycle pop+push reloads and stays full.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr <= push_addr;
            data <= push_data;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the instruction cache (read-only) and
// the data cache (read + write). Read grants are held for a cache-line burst,
// returning words are routed by an owner-tag pipeline, and data-cache writes
// go through a one-entry write buffer.
//   ic_rd_*  : icache read request / returned word
//   dc_rd_*  : dcache read request / returned word
//   dc_wr_*  : dcache write request, dc_wr_rdy = buffer can accept
//   mem_rd_* : memory read issue channel and returning data
//   mem_wr_* : memory write channel (independent of reads)
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int LINE_WIDTH     = 4,
    parameter int MEM_RD_LATENCY = 2,
    parameter int MAX_HOLD       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] ic_rd_addr,
    input  logic                  ic_rd_en,
    output logic [DATA_WIDTH-1:0] ic_rd_data,
    output logic                  ic_rd_valid,
    input  logic [ADDR_WIDTH-1:0] dc_rd_addr,
    input  logic                  dc_rd_en,
    output logic [DATA_WIDTH-1:0] dc_rd_data,
    output logic                  dc_rd_valid,
    input  logic [ADDR_WIDTH-1:0] dc_wr_addr,
    input  logic [DATA_WIDTH-1:0] dc_wr_data,
    input  logic                  dc_wr_en,
    output logic                  dc_wr_rdy,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    output logic                  mem_rd_en,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    input  logic                  mem_rd_valid,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic                  mem_wr_en,
    input  logic                  mem_wr_rdy
);

    localparam int OFS = line_ofs(LINE_WIDTH);
    localparam int LAT = MEM_RD_LATENCY;
    localparam int HW  = $clog2(MAX_HOLD + 1);
    localparam int LW  = ADDR_WIDTH - OFS;

    state_t          state;
    owner_t          last_grant;
    logic [LW-1:0]   line;
    logic [HW-1:0]   hold_cnt;
    rd_tag_t         tag_p [LAT];

    owner_t                owner;
    logic                  sel_en;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic                  other_req;
    logic                  line_chg;
    logic                  hold_max;
    logic                  rel;
    logic                  hazard;

    logic                  wb_full;
    logic                  wb_push;
    logic                  wb_pop;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0] wb_data;

    // Current owner's request; everything is zero while idle.
    always_comb begin
        owner     = OWN_NONE;
        sel_en    = 1'b0;
        sel_addr  = '0;
        other_req = 1'b0;
        case (state)
            ST_OWN_IC: begin
                owner     = OWN_IC;
                sel_en    = ic_rd_en;
                sel_addr  = ic_rd_addr;
                other_req = dc_rd_en;
            end
            ST_OWN_DC: begin
                owner     = OWN_DC;
                sel_en    = dc_rd_en;
                sel_addr  = dc_rd_addr;
                other_req = ic_rd_en;
            end
            default: ;
        endcase
    end

    // A read to the address still sitting in the write buffer must wait for
    // the write to drain; the grant is kept meanwhile.
    assign hazard      = wb_full & (sel_addr == wb_addr);
    assign mem_rd_en   = sel_en & ~hazard;
    assign mem_rd_addr = sel_addr;

    assign line_chg = (sel_addr[ADDR_WIDTH-1:OFS] != line);
    assign hold_max = (hold_cnt == HW'(MAX_HOLD - 1));
    // Line changes and hold expiry only give up the grant when someone waits.
    assign rel      = ~sel_en | (other_req & (line_chg | hold_max));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= OWN_IC;
            line       <= '0;
            hold_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    hold_cnt <= '0;
                    if (ic_rd_en && (!dc_rd_en || last_grant == OWN_DC)) begin
                        state <= ST_OWN_IC;
                        line  <= ic_rd_addr[ADDR_WIDTH-1:OFS];
                    end else if (dc_rd_en) begin
                        state <= ST_OWN_DC;
                        line  <= dc_rd_addr[ADDR_WIDTH-1:OFS];
                    end
                end
                default: begin
                    if (!hold_max) hold_cnt <= hold_cnt + 1'b1;
                    if (rel) begin
                        state      <= ST_IDLE;
                        last_grant <= owner;
                    end else if (line_chg) begin
                        line <= sel_addr[ADDR_WIDTH-1:OFS];
                    end
                end
            endcase
        end
    end

    // ---- tag pipeline: issue -> return, one stage per cycle of latency ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) tag_p[i] <= '{vld: 1'b0, owner: OWN_NONE};
        end else begin
            tag_p[0] <= '{vld: mem_rd_en, owner: owner};
            for (int i = 1; i < LAT; i++) tag_p[i] <= tag_p[i-1];
        end
    end

    // ---- return routing ----
    assign ic_rd_valid = mem_rd_valid & tag_p[LAT-1].vld & (tag_p[LAT-1].owner == OWN_IC);
    assign dc_rd_valid = mem_rd_valid & tag_p[LAT-1].vld & (tag_p[LAT-1].owner == OWN_DC);
    assign ic_rd_data  = mem_rd_data;
    assign dc_rd_data  = mem_rd_data;

    // ---- write path ----
    assign wb_pop    = wb_full & mem_wr_rdy;
    assign dc_wr_rdy = ~wb_full | mem_wr_rdy;
    assign wb_push   = dc_wr_en & dc_wr_rdy;

    mem_wr_buffer #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_buffer (
        .clk       (clk),
        .rst       (rst),
        .push      (wb_push),
        .pop       (wb_pop),
        .push_addr (dc_wr_addr),
        .push_data (dc_wr_data),
        .full      (wb_full),
        .addr      (wb_addr),
        .data      (wb_data)
    );

    // Buffer storage is not reset, so the port is gated to read zero when empty.
    assign mem_wr_en   = wb_full;
    assign mem_wr_addr = wb_full ? wb_addr : '0;
    assign mem_wr_data = wb_full ? wb_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ic_rd_addr = '0;
    logic        ic_rd_en = 1'b0;
    logic [31:0] ic_rd_data;
    logic        ic_rd_valid;
    logic [15:0] dc_rd_addr = '0;
    logic        dc_rd_en = 1'b0;
    logic [31:0] dc_rd_data;
    logic        dc_rd_valid;
    logic [15:0] dc_wr_addr = '0;
    logic [31:0] dc_wr_data = '0;
    logic        dc_wr_en = 1'b0;
    logic        dc_wr_rdy;
    logic [15:0] mem_rd_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data;
    logic        mem_rd_valid;
    logic [15:0] mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_en;
    logic        mem_wr_rdy = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .ic_rd_addr   (ic_rd_addr),
        .ic_rd_en     (ic_rd_en),
        .ic_rd_data   (ic_rd_data),
        .ic_rd_valid  (ic_rd_valid),
        .dc_rd_addr   (dc_rd_addr),
        .dc_rd_en     (dc_rd_en),
        .dc_rd_data   (dc_rd_data),
        .dc_rd_valid  (dc_rd_valid),
        .dc_wr_addr   (dc_wr_addr),
        .dc_wr_data   (dc_wr_data),
        .dc_wr_en     (dc_wr_en),
        .dc_wr_rdy    (dc_wr_rdy),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid),
        .mem_wr_addr  (mem_wr_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_en    (mem_wr_en),
        .mem_wr_rdy   (mem_wr_rdy)
    );

    // Memory model: word = addr*addr unless written, read latency 2.
    logic [31:0] wmem [int];
    logic        cap_vld = 1'b0;
    logic [15:0] cap_addr = '0;
    logic        s1_vld = 1'b0;
    logic [15:0] s1_addr = '0;
    logic        s2_vld = 1'b0;
    logic [31:0] s2_data = '0;
    logic        drop = 1'b0;

    function automatic logic [31:0] mem_val(input logic [15:0] a);
        if (wmem.exists(int'(a))) return wmem[int'(a)];
        return 32'(a) * 32'(a);
    endfunction

    always @(negedge clk) begin
        cap_vld  = mem_rd_en;
        cap_addr = mem_rd_addr;
        if (mem_wr_en && mem_wr_rdy) wmem[int'(mem_wr_addr)] = mem_wr_data;
    end

    always @(posedge clk) begin
        s2_vld  = s1_vld;
        s2_data = s1_vld ? mem_val(s1_addr) : 32'd0;
        s1_vld  = cap_vld;
        s1_addr = cap_addr;
    end

    assign mem_rd_valid = s2_vld & ~drop;
    assign mem_rd_data  = s2_data;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ic_rd_en = 1'b0;
        dc_rd_en = 1'b0;
        dc_wr_en = 1'b0;
        mem_wr_rdy = 1'b1;
        drop = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state (mem_wr_rdy=0 so dc_wr_rdy=1 must come from an empty buffer)
        repeat (2) tick();
        #2;
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_rd_addr", mem_rd_addr, 0);
        chk("rst_mem_wr_en", mem_wr_en, 0);
        chk("rst_mem_wr_addr", mem_wr_addr, 0);
        chk("rst_mem_wr_data", mem_wr_data, 0);
        chk("rst_ic_vld", ic_rd_valid, 0);
        chk("rst_dc_vld", dc_rd_valid, 0);
        chk("rst_dc_wr_rdy", dc_wr_rdy, 1);

        // 1: icache streams addr 0..7 across a line boundary
        do_reset();
        ic_rd_en = 1'b1; ic_rd_addr = 16'd0;
        #2;
        chk("t1_idle_rd_en", mem_rd_en, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            ic_rd_en   = (k <= 8);
            ic_rd_addr = (k <= 8) ? 16'(k - 1) : 16'd0;
            #2;
            chk("t1_rd_en", mem_rd_en, (k <= 8));
            if (k <= 8) chk("t1_rd_addr", mem_rd_addr, k - 1);
            chk("t1_ic_vld", ic_rd_valid, (k >= 3));
            if (k >= 3) chk("t1_ic_data", ic_rd_data, (k - 3) * (k - 3));
            chk("t1_dc_vld", dc_rd_valid, 0);
        end

        // 2: simultaneous requests from reset, DC wins first
        do_reset();
        ic_rd_en = 1'b1; ic_rd_addr = 16'd3;
        dc_rd_en = 1'b1; dc_rd_addr = 16'd512;
        tick(); #2;
        chk("t2_c1_rd_en", mem_rd_en, 1);
        chk("t2_c1_rd_addr", mem_rd_addr, 512);
        tick(); dc_rd_addr = 16'd513; #2;
        chk("t2_c2_rd_addr", mem_rd_addr, 513);
        tick(); dc_rd_en = 1'b0; #2;
        chk("t2_c3_rd_en", mem_rd_en, 0);
        chk("t2_c3_dc_vld", dc_rd_valid, 1);
        chk("t2_c3_dc_data", dc_rd_data, 262144);
        chk("t2_c3_ic_vld", ic_rd_valid, 0);
        tick(); #2;
        chk("t2_c4_rd_en", mem_rd_en, 0);
        chk("t2_c4_dc_vld", dc_rd_valid, 1);
        chk("t2_c4_dc_data", dc_rd_data, 263169);
        chk("t2_c4_ic_vld", ic_rd_valid, 0);
        tick(); #2;
        chk("t2_c5_rd_en", mem_rd_en, 1);
        chk("t2_c5_rd_addr", mem_rd_addr, 3);
        chk("t2_c5_dc_vld", dc_rd_valid, 0);
        tick(); ic_rd_en = 1'b0; #2;
        chk("t2_c6_ic_vld", ic_rd_valid, 0);
        tick(); #2;
        chk("t2_c7_ic_vld", ic_rd_valid, 1);
        chk("t2_c7_ic_data", ic_rd_data, 9);
        chk("t2_c7_dc_vld", dc_rd_valid, 0);

        // 3: MAX_HOLD fairness
        do_reset();
        dc_rd_en = 1'b1; dc_rd_addr = 16'd32;
        ic_rd_en = 1'b1; ic_rd_addr = 16'd64;
        for (int k = 1; k <= 10; k++) begin
            tick(); #2;
            chk("t3_rd_en", mem_rd_en, (k != 9));
            chk("t3_rd_addr", mem_rd_addr, (k <= 8) ? 32 : ((k == 10) ? 64 : 0));
            chk("t3_dc_vld", dc_rd_valid, (k >= 3));
        end
        tick(); ic_rd_en = 1'b0; dc_rd_en = 1'b0; #2;
        chk("t3_c11_dc_vld", dc_rd_valid, 0);
        chk("t3_c11_ic_vld", ic_rd_valid, 0);
        tick(); #2;
        chk("t3_c12_ic_vld", ic_rd_valid, 1);
        chk("t3_c12_ic_data", ic_rd_data, 4096);

        // 4: buffered write blocks a read of the same address
        do_reset();
        mem_wr_rdy = 1'b0;
        dc_wr_en = 1'b1; dc_wr_addr = 16'd16; dc_wr_data = 32'd80;
        #2;
        chk("t4_c0_wr_rdy", dc_wr_rdy, 1);
        chk("t4_c0_mem_wr_en", mem_wr_en, 0);
        tick(); dc_wr_en = 1'b0; dc_rd_en = 1'b1; dc_rd_addr = 16'd16; #2;
        chk("t4_c1_wr_rdy", dc_wr_rdy, 0);
        chk("t4_c1_mem_wr_en", mem_wr_en, 1);
        chk("t4_c1_mem_wr_addr", mem_wr_addr, 16);
        chk("t4_c1_mem_wr_data", mem_wr_data, 80);
        tick(); #2;
        chk("t4_c2_rd_en", mem_rd_en, 0);
        chk("t4_c2_rd_addr", mem_rd_addr, 16);
        chk("t4_c2_wr_rdy", dc_wr_rdy, 0);
        tick(); #2;
        chk("t4_c3_rd_en", mem_rd_en, 0);
        tick(); mem_wr_rdy = 1'b1; #2;
        chk("t4_c4_wr_rdy", dc_wr_rdy, 1);
        chk("t4_c4_mem_wr_en", mem_wr_en, 1);
        chk("t4_c4_rd_en", mem_rd_en, 0);
        tick(); #2;
        chk("t4_c5_mem_wr_en", mem_wr_en, 0);
        chk("t4_c5_rd_en", mem_rd_en, 1);
        chk("t4_c5_rd_addr", mem_rd_addr, 16);
        tick(); dc_rd_en = 1'b0; #2;
        chk("t4_c6_dc_vld", dc_rd_valid, 0);
        tick(); #2;
        chk("t4_c7_dc_vld", dc_rd_valid, 1);
        chk("t4_c7_dc_data", dc_rd_data, 80);

        // 5: memory drops a returning beat
        do_reset();
        ic_rd_en = 1'b1; ic_rd_addr = 16'd1;
        tick();
        tick(); ic_rd_addr = 16'd2;
        tick(); ic_rd_en = 1'b0; drop = 1'b1; #2;
        chk("t5_c3_ic_vld", ic_rd_valid, 0);
        chk("t5_c3_dc_vld", dc_rd_valid, 0);
        tick(); drop = 1'b0; #2;
        chk("t5_c4_ic_vld", ic_rd_valid, 1);
        chk("t5_c4_ic_data", ic_rd_data, 4);

        // 6: reset mid-burst with reads in flight and a held write
        do_reset();
        ic_rd_en = 1'b1; ic_rd_addr = 16'd8;
        tick(); mem_wr_rdy = 1'b0; dc_wr_en = 1'b1; dc_wr_addr = 16'd100; dc_wr_data = 32'd5;
        tick(); dc_wr_en = 1'b0; ic_rd_addr = 16'd9; #2;
        chk("t6_c2_mem_wr_en", mem_wr_en, 1);
        tick(); rst = 1'b1; ic_rd_addr = 16'd10; #2;
        chk("t6_c3_ic_vld", ic_rd_valid, 1);
        chk("t6_c3_ic_data", ic_rd_data, 64);
        tick(); ic_rd_en = 1'b0; #2;
        chk("t6_c4_ic_vld", ic_rd_valid, 0);
        chk("t6_c4_dc_vld", dc_rd_valid, 0);
        chk("t6_c4_rd_en", mem_rd_en, 0);
        chk("t6_c4_rd_addr", mem_rd_addr, 0);
        chk("t6_c4_mem_wr_en", mem_wr_en, 0);
        chk("t6_c4_mem_wr_addr", mem_wr_addr, 0);
        chk("t6_c4_wr_rdy", dc_wr_rdy, 1);
        tick(); #2;
        chk("t6_c5_ic_vld", ic_rd_valid, 0);
        chk("t6_c5_dc_vld", dc_rd_valid, 0);
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
